// File: rtl/fifo_pkg.sv
// Shared constants and occupancy encoding for the fifo_sync / fifo_rd_ctrl pair.
package fifo_pkg;

    localparam int MEMORY_WIDTH = 4;
    localparam int MEMORY_DEPTH = 4;
    localparam int ADDRESS_SIZE = $clog2(MEMORY_DEPTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } occ_state_t;

    function automatic logic [1:0] occ_level(input occ_state_t s);
        case (s)
            S_ONE:   return 2'd1;
            S_FULL:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry output buffer; slot0 is always the head word, slot1 shifts forward on pop.
module fifo_rd_skid #(
    parameter int WIDTH = fifo_pkg::MEMORY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic [1:0]       level
);
    import fifo_pkg::*;

    occ_state_t       state;
    occ_state_t       state_next;
    logic [WIDTH-1:0] slot0;
    logic [WIDTH-1:0] slot1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_EMPTY: begin
                if (push) state_next = S_ONE;
            end
            S_ONE: begin
                if (push && !pop)      state_next = S_FULL;
                else if (!push && pop) state_next = S_EMPTY;
            end
            S_FULL: begin
                if (!push && pop) state_next = S_ONE;
            end
            default: state_next = S_EMPTY;
        endcase
    end

    always_comb begin
        valid = (state != S_EMPTY);
        level = occ_level(state);
        head  = slot0;
    end

    // A push into a full buffer only happens alongside a pop, so the new word lands in the freed slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (push) slot0 <= push_data;
                end
                S_ONE: begin
                    if (push && pop) slot0 <= push_data;
                    else if (push)   slot1 <= push_data;
                end
                S_FULL: begin
                    if (pop) begin
                        slot0 <= slot1;
                        if (push) slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for fifo_sync: issues reads, tracks the in-flight word and
// presents the buffered words on a valid/ready stream with a delivered-word counter.
module fifo_rd_ctrl #(
    parameter int MEMORY_WIDTH = fifo_pkg::MEMORY_WIDTH,
    parameter int COUNT_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    EMPTY,
    output logic                    r_en,
    input  logic [MEMORY_WIDTH-1:0] RD,
    output logic [MEMORY_WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COUNT_WIDTH-1:0]  rd_count
);
    logic       pop;
    logic       inflight;
    logic [1:0] level;
    logic [2:0] pending;

    assign pop = out_valid & out_ready;

    // Slots already claimed once this cycle's pop is accounted for; pop implies level >= 1.
    assign pending = {1'b0, level} + {2'b00, inflight} - {2'b00, pop};
    assign r_en    = ~rst & en & ~EMPTY & (pending < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= 1'b0;
            rd_count <= '0;
        end else begin
            inflight <= r_en;
            if (pop) rd_count <= rd_count + 1'b1;
        end
    end

    fifo_rd_skid #(
        .WIDTH(MEMORY_WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(RD),
        .pop      (pop),
        .head     (out_data),
        .valid    (out_valid),
        .level    (level)
    );

endmodule
